// File: rtl/tri_gen.sv
// Free-running 9-bit triangle-wave generator: ramp up, hold at PEAK, ramp down, hold at 0.
// Hold plateaus and their counter exist only when TRI_GEN_HOLD_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------
// RISE     | d_out climbs by STEP, clamped to PEAK
// TOP_HOLD | d_out parked at PEAK for HOLD_TOP cycles
// FALL     | d_out drops by STEP, clamped to 0
// BOT_HOLD | d_out parked at 0 for HOLD_BOT cycles
module tri_gen #(
    parameter int unsigned PEAK     = 299,
    parameter int unsigned STEP     = 1,
    parameter int unsigned HOLD_TOP = 200,
    parameter int unsigned HOLD_BOT = 200
) (
    input  logic       clk,
    input  logic       res,
    output logic [8:0] d_out
);

    if (PEAK < 1 || PEAK > 511) begin : g_bad_peak
        $fatal(1, "tri_gen: PEAK must be in 1..511");
    end
    if (STEP < 1 || STEP > PEAK) begin : g_bad_step
        $fatal(1, "tri_gen: STEP must be in 1..PEAK");
    end
    if (HOLD_TOP > 65536 || HOLD_BOT > 65536) begin : g_bad_hold
        $fatal(1, "tri_gen: hold lengths must fit the 16-bit hold counter");
    end

    localparam logic [9:0] PEAK_W = 10'(PEAK);
    localparam logic [9:0] STEP_W = 10'(STEP);

`ifdef TRI_GEN_HOLD_EN
    typedef enum logic [1:0] {RISE, TOP_HOLD, FALL, BOT_HOLD} state_t;

    localparam logic [15:0] TOP_LAST = (HOLD_TOP == 0) ? 16'd0 : 16'(HOLD_TOP - 1);
    localparam logic [15:0] BOT_LAST = (HOLD_BOT == 0) ? 16'd0 : 16'(HOLD_BOT - 1);

    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
`else
    typedef enum logic {RISE, FALL} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  d_nxt;
    logic [9:0]  sum;

    always_comb begin
        sum       = {1'b0, d_out} + STEP_W;
        state_nxt = state;
        d_nxt     = d_out;
`ifdef TRI_GEN_HOLD_EN
        cnt_nxt   = cnt;
`endif
        case (state)
            RISE: begin
                if (sum >= PEAK_W) begin
                    d_nxt = PEAK_W[8:0];
`ifdef TRI_GEN_HOLD_EN
                    cnt_nxt   = '0;
                    state_nxt = (HOLD_TOP == 0) ? FALL : TOP_HOLD;
`else
                    state_nxt = FALL;
`endif
                end else begin
                    d_nxt = sum[8:0];
                end
            end
            FALL: begin
                if ({1'b0, d_out} <= STEP_W) begin
                    d_nxt = '0;
`ifdef TRI_GEN_HOLD_EN
                    cnt_nxt   = '0;
                    state_nxt = (HOLD_BOT == 0) ? RISE : BOT_HOLD;
`else
                    state_nxt = RISE;
`endif
                end else begin
                    d_nxt = d_out - STEP_W[8:0];
                end
            end
`ifdef TRI_GEN_HOLD_EN
            TOP_HOLD: begin
                if (cnt == TOP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = FALL;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            BOT_HOLD: begin
                if (cnt == BOT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = RISE;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
`endif
            default: state_nxt = RISE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state <= RISE;
            d_out <= '0;
`ifdef TRI_GEN_HOLD_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
            d_out <= d_nxt;
`ifdef TRI_GEN_HOLD_EN
            cnt   <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_tri_gen.sv
// Self-checking bench for tri_gen: per-edge scoreboard against a timeline model,
// spot-check table, and hand-written reset sequences. Three parameterisations run side by side.
module tb_tri_gen;

    logic       clk;
    logic       res;
    logic [8:0] d_a;
    logic [8:0] d_b;
    logic [8:0] d_c;

`ifdef TRI_GEN_HOLD_EN
    localparam int HT_A = 200;
    localparam int HB_A = 200;
`else
    localparam int HT_A = 0;
    localparam int HB_A = 0;
`endif
    localparam int NRUN = 1100;

    tri_gen u_a (.clk(clk), .res(res), .d_out(d_a));
    tri_gen #(.PEAK(10), .STEP(3), .HOLD_TOP(0), .HOLD_BOT(0))
        u_b (.clk(clk), .res(res), .d_out(d_b));
    tri_gen #(.PEAK(511), .STEP(511), .HOLD_TOP(0), .HOLD_BOT(0))
        u_c (.clk(clk), .res(res), .d_out(d_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int qa[$];
    int qb[$];
    int qc[$];
    int hist_a[0:NRUN];
    int hist_b[0:NRUN];
    int hist_c[0:NRUN];
    int max_a  = 0;
    int max_b  = 0;

    typedef struct {
        int inst;
        int edge_n;
        int exp;
    } vec_t;
    vec_t tbl[21];

    // Expected sample at edge n (1-based after reset release), from the waveform timeline.
    function automatic int model(int n, int peak, int step, int ht, int hb);
        int r;
        int p;
        int m;
        r = (peak + step - 1) / step;
        p = 2 * r + ht + hb;
        m = (n - 1) % p;
        if (m < r) return ((m + 1) * step > peak) ? peak : (m + 1) * step;
        m -= r;
        if (m < ht) return peak;
        m -= ht;
        if (m < r) return (peak - (m + 1) * step < 0) ? 0 : peak - (m + 1) * step;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic pop_check(input string name, inout int q[$], input int act);
        int e;
        if (q.size() == 0) begin
            total++;
            $display("FAIL %s: got %0d expected queued value (queue empty)", name, act);
        end else begin
            e = q.pop_front();
            check(name, act, e);
        end
    endtask

    task automatic step(input int n, input bit log_it);
        qa.push_back(model(n, 299, 1, HT_A, HB_A));
        qb.push_back(model(n, 10, 3, 0, 0));
        qc.push_back(model(n, 511, 511, 0, 0));
        @(posedge clk);
        #1;
        pop_check("sb_a", qa, int'(d_a));
        pop_check("sb_b", qb, int'(d_b));
        pop_check("sb_c", qc, int'(d_c));
        if (log_it) begin
            hist_a[n] = int'(d_a);
            hist_b[n] = int'(d_b);
            hist_c[n] = int'(d_c);
            if (int'(d_a) > max_a) max_a = int'(d_a);
            if (int'(d_b) > max_b) max_b = int'(d_b);
        end
    endtask

    initial begin
        int e_fall;

`ifdef TRI_GEN_HOLD_EN
        tbl[0] = '{0, 1, 1};     tbl[1] = '{0, 2, 2};     tbl[2] = '{0, 299, 299};
        tbl[3] = '{0, 300, 299}; tbl[4] = '{0, 499, 299}; tbl[5] = '{0, 500, 298};
        tbl[6] = '{0, 798, 0};   tbl[7] = '{0, 998, 0};   tbl[8] = '{0, 999, 1};
`else
        tbl[0] = '{0, 1, 1};     tbl[1] = '{0, 2, 2};     tbl[2] = '{0, 299, 299};
        tbl[3] = '{0, 300, 298}; tbl[4] = '{0, 597, 1};   tbl[5] = '{0, 598, 0};
        tbl[6] = '{0, 599, 1};   tbl[7] = '{0, 897, 299}; tbl[8] = '{0, 898, 298};
`endif
        tbl[9]  = '{1, 1, 3};  tbl[10] = '{1, 2, 6};  tbl[11] = '{1, 3, 9};
        tbl[12] = '{1, 4, 10}; tbl[13] = '{1, 5, 7};  tbl[14] = '{1, 6, 4};
        tbl[15] = '{1, 7, 1};  tbl[16] = '{1, 8, 0};  tbl[17] = '{1, 9, 3};
        tbl[18] = '{2, 1, 511}; tbl[19] = '{2, 2, 0}; tbl[20] = '{2, 3, 511};

        res = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_a", int'(d_a), 0);
            check("reset_b", int'(d_b), 0);
            check("reset_c", int'(d_c), 0);
        end
        res = 1'b0;

        for (int n = 1; n <= NRUN; n++) step(n, 1'b1);

        for (int i = 0; i < 21; i++) begin
            case (tbl[i].inst)
                0:       check($sformatf("tbl_a_edge%0d", tbl[i].edge_n), hist_a[tbl[i].edge_n], tbl[i].exp);
                1:       check($sformatf("tbl_b_edge%0d", tbl[i].edge_n), hist_b[tbl[i].edge_n], tbl[i].exp);
                default: check($sformatf("tbl_c_edge%0d", tbl[i].edge_n), hist_c[tbl[i].edge_n], tbl[i].exp);
            endcase
        end
        check("max_a_le_peak", (max_a <= 299) ? 1 : 0, 1);
        check("max_b_le_peak", (max_b <= 10) ? 1 : 0, 1);

        // Restart, run into the falling ramp at 150, then reset for a single edge.
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        qa.delete();
        qb.delete();
        qc.delete();
        e_fall = 0;
        for (int n = 2; n < 2000 && e_fall == 0; n++)
            if (model(n, 299, 1, HT_A, HB_A) == 150 && model(n - 1, 299, 1, HT_A, HB_A) == 151)
                e_fall = n;
        for (int n = 1; n <= e_fall; n++) step(n, 1'b0);
        check("pre_reset_fall", int'(d_a), 150);
        res = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_a", int'(d_a), 0);
        check("mid_reset_b", int'(d_b), 0);
        res = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_rise_a", int'(d_a), 1);
        check("post_reset_rise_b", int'(d_b), 3);
        check("post_reset_rise_c", int'(d_c), 511);
        @(posedge clk);
        #1;
        check("post_reset_rise2_a", int'(d_a), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
